// File: rtl/ctrl_rtc_pkg.sv
// ctrl_rtc_pkg
// Shared definitions for the RTC edit sequencer: FSM state encoding, field
// cursor indices, legal field ranges, RTC register base addresses, the fixed
// RTC init write table and small conversion helpers.
// No ports (package).

package ctrl_rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_INIT   = 2'd3
    } state_t;

    // Cursor indices. The timer bank uses only the first three.
    localparam logic [2:0] F_SEC   = 3'd0;
    localparam logic [2:0] F_MIN   = 3'd1;
    localparam logic [2:0] F_HOUR  = 3'd2;
    localparam logic [2:0] F_DAY   = 3'd3;
    localparam logic [2:0] F_MONTH = 3'd4;
    localparam logic [2:0] F_YEAR  = 3'd5;

    localparam logic [2:0] CLOCK_LAST = 3'd5;
    localparam logic [2:0] TIMER_LAST = 3'd2;
    localparam logic [2:0] INIT_LAST  = 3'd2;

    // Field ranges (binary).
    localparam logic [6:0] SEC_MIN    = 7'd0;
    localparam logic [6:0] SEC_MAX    = 7'd59;
    localparam logic [6:0] MIN_MIN    = 7'd0;
    localparam logic [6:0] MIN_MAX    = 7'd59;
    localparam logic [6:0] HOUR24_MIN = 7'd0;
    localparam logic [6:0] HOUR24_MAX = 7'd23;
    localparam logic [6:0] HOUR12_MIN = 7'd1;
    localparam logic [6:0] HOUR12_MAX = 7'd12;
    localparam logic [6:0] DAY_MIN    = 7'd1;
    localparam logic [6:0] DAY_MAX    = 7'd31;
    localparam logic [6:0] MONTH_MIN  = 7'd1;
    localparam logic [6:0] MONTH_MAX  = 7'd12;
    localparam logic [6:0] YEAR_MIN   = 7'd0;
    localparam logic [6:0] YEAR_MAX   = 7'd99;

    localparam logic [7:0] CLOCK_BASE = 8'h21;
    localparam logic [7:0] TIMER_BASE = 8'h41;

    // Init sequence, {addr, data}; entry 0 is written first.
    localparam logic [2:0][15:0] INIT_TBL = {16'h10D2, 16'h0200, 16'h0210};

    // Binary (0..99) to two-digit packed BCD.
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Hour remap applied when switching into 12 h mode.
    function automatic logic [6:0] hour_to_12h(input logic [6:0] h);
        if (h == 7'd0)
            return 7'd12;
        else if (h >= 7'd13 && h <= 7'd23)
            return h - 7'd12;
        else
            return h;
    endfunction

endpackage

// File: rtl/campo_paso.sv
// campo_paso
// Steps one field value by +1/-1 with wrap-around inside [min_val, max_val].
// A value outside the range (e.g. an hour left above 12 in 12 h mode) is
// clamped as part of the step: up goes to min_val, down goes to max_val.
// Ports:
//   value    in  7  current binary value
//   min_val  in  7  range minimum
//   max_val  in  7  range maximum
//   up       in  1  1 = increment, 0 = decrement
//   next_val out 7  wrapped next value

module campo_paso (
    input  logic [6:0] value,
    input  logic [6:0] min_val,
    input  logic [6:0] max_val,
    input  logic       up,
    output logic [6:0] next_val
);

    always_comb begin
        if (up)
            next_val = (value >= max_val || value < min_val) ? min_val : value + 7'd1;
        else
            next_val = (value <= min_val || value > max_val) ? max_val : value - 7'd1;
    end

endmodule

// File: rtl/ctrl_edicion_rtc.sv
// ctrl_edicion_rtc
// Sequencer between the keyboard decoder pulses and the RTC write port.
// Keeps an editable shadow of the clock fields (sec, min, hour, day, month,
// year) and timer fields (sec, min, hour), moves a field cursor, steps values
// within their ranges and streams register writes to the RTC interface.
//
// Optional feature: define CTRL_EDIT_TIMEOUT_EN to leave EDIT automatically
// after TIMEOUT_CYCLES cycles without any key pulse.
//
// Write handshake: wr_req/wr_addr/wr_data are held stable until wr_ack is
// sampled high while wr_req is high; wr_req then drops for exactly one cycle
// before the next item is requested. wr_ack with wr_req low is ignored.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous reset, active low
//   configurate    in   pulse: enter/leave EDIT
//   write          in   pulse: commit selected bank
//   inicializate   in   pulse: run RTC init sequence
//   arriba, abajo  in   pulses: increment/decrement field under cursor
//   izquierda,
//   derecha        in   pulses: move cursor left/right (wrapping)
//   clock_timer    in   level: 0 clock bank, 1 timer bank
//   T24_12         in   level: 0 24 h, 1 12 h
//   wr_ack         in   RTC accepted current write
//   wr_req         out  write request
//   wr_addr[7:0]   out  RTC register address
//   wr_data[7:0]   out  RTC register data
//   editing        out  high in EDIT
//   busy           out  high in COMMIT/INIT
//   cursor[2:0]    out  current field index
//   cursor_val[7:0] out BCD of field under cursor
//   fsm_state      out  current FSM state (debug)

module ctrl_edicion_rtc
    import ctrl_rtc_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       configurate,
    input  logic       write,
    input  logic       inicializate,
    input  logic       arriba,
    input  logic       abajo,
    input  logic       izquierda,
    input  logic       derecha,
    input  logic       clock_timer,
    input  logic       T24_12,
    input  logic       wr_ack,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       editing,
    output logic       busy,
    output logic [2:0] cursor,
    output logic [7:0] cursor_val,
    output state_t     fsm_state
);

    state_t     state;
    logic [2:0] idx;        // item being written in COMMIT/INIT
    logic       bank_q;     // bank latched when COMMIT starts
    logic       ct_q;       // previous clock_timer, for bank-change detect
    logic       t12_q;      // previous T24_12, for 12 h entry detect

    logic [6:0] c_sec, c_min, c_hour, c_day, c_month, c_year;
    logic [6:0] t_sec, t_min, t_hour;

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Pulse decode with fixed priority; lower pulses in the same cycle
    // are dropped.
    // ------------------------------------------------------------------
    logic can_cmd, in_edit, bank_chg, hi_pulse, arrows_ok;
    logic act_ini, act_wr, act_cfg, act_up, act_dn, act_r, act_l;
    logic timeout_hit;

    assign can_cmd  = (state == ST_IDLE) || (state == ST_EDIT);
    assign in_edit  = (state == ST_EDIT);
    assign bank_chg = (clock_timer != ct_q);
    assign hi_pulse = inicializate | write | configurate;

    assign act_ini = can_cmd && inicializate;
    assign act_wr  = can_cmd && write && !inicializate;
    assign act_cfg = can_cmd && configurate && !inicializate && !write;

    // A bank change forces the cursor to 0; arrows in that cycle would
    // refer to the wrong bank, so they are dropped.
    assign arrows_ok = in_edit && !hi_pulse && !bank_chg;
    assign act_up    = arrows_ok && arriba;
    assign act_dn    = arrows_ok && abajo && !arriba;
    assign act_r     = arrows_ok && derecha && !arriba && !abajo;
    assign act_l     = arrows_ok && izquierda && !arriba && !abajo && !derecha;

`ifdef CTRL_EDIT_TIMEOUT_EN
    logic        any_key;
    logic [31:0] idle_cnt;

    assign any_key = hi_pulse | arriba | abajo | izquierda | derecha;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            idle_cnt <= '0;
        else if (!in_edit || any_key)
            idle_cnt <= '0;
        else if (idle_cnt != TIMEOUT_CYCLES)
            idle_cnt <= idle_cnt + 32'd1;
    end

    assign timeout_hit = in_edit && !any_key && (idle_cnt == TIMEOUT_CYCLES);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Field under the cursor and its range.
    // ------------------------------------------------------------------
    logic [2:0] last_idx;
    logic [6:0] sel_val, sel_min, sel_max, step_next;
    logic       sel_ok, field_en;

    assign last_idx = clock_timer ? TIMER_LAST : CLOCK_LAST;

    always_comb begin
        sel_val = '0;
        sel_min = '0;
        sel_max = '0;
        sel_ok  = 1'b0;
        if (cursor <= last_idx) begin
            sel_ok = 1'b1;
            case (cursor)
                F_SEC: begin
                    sel_val = clock_timer ? t_sec : c_sec;
                    sel_min = SEC_MIN;
                    sel_max = SEC_MAX;
                end
                F_MIN: begin
                    sel_val = clock_timer ? t_min : c_min;
                    sel_min = MIN_MIN;
                    sel_max = MIN_MAX;
                end
                F_HOUR: begin
                    sel_val = clock_timer ? t_hour : c_hour;
                    sel_min = T24_12 ? HOUR12_MIN : HOUR24_MIN;
                    sel_max = T24_12 ? HOUR12_MAX : HOUR24_MAX;
                end
                F_DAY: begin
                    sel_val = c_day;
                    sel_min = DAY_MIN;
                    sel_max = DAY_MAX;
                end
                F_MONTH: begin
                    sel_val = c_month;
                    sel_min = MONTH_MIN;
                    sel_max = MONTH_MAX;
                end
                F_YEAR: begin
                    sel_val = c_year;
                    sel_min = YEAR_MIN;
                    sel_max = YEAR_MAX;
                end
                default: sel_ok = 1'b0;
            endcase
        end
    end

    campo_paso u_paso (
        .value    (sel_val),
        .min_val  (sel_min),
        .max_val  (sel_max),
        .up       (act_up),
        .next_val (step_next)
    );

    assign field_en   = (act_up || act_dn) && sel_ok;
    assign cursor_val = bin2bcd(sel_val);

    // ------------------------------------------------------------------
    // Shadow field registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sec   <= SEC_MIN;
            c_min   <= MIN_MIN;
            c_hour  <= HOUR24_MIN;
            c_day   <= DAY_MIN;
            c_month <= MONTH_MIN;
            c_year  <= YEAR_MIN;
            t_sec   <= SEC_MIN;
            t_min   <= MIN_MIN;
            t_hour  <= HOUR24_MIN;
            ct_q    <= 1'b0;
            t12_q   <= 1'b0;
        end else begin
            ct_q  <= clock_timer;
            t12_q <= T24_12;
            if (field_en) begin
                case (cursor)
                    F_SEC:   if (clock_timer) t_sec  <= step_next; else c_sec  <= step_next;
                    F_MIN:   if (clock_timer) t_min  <= step_next; else c_min  <= step_next;
                    F_HOUR:  if (clock_timer) t_hour <= step_next; else c_hour <= step_next;
                    F_DAY:   c_day   <= step_next;
                    F_MONTH: c_month <= step_next;
                    F_YEAR:  c_year  <= step_next;
                    default: ;
                endcase
            end
            // Entering 12 h mode remaps both hour registers; this wins over
            // a step in the same cycle. Leaving 12 h keeps the values.
            if (T24_12 && !t12_q) begin
                c_hour <= hour_to_12h(c_hour);
                t_hour <= hour_to_12h(t_hour);
            end
        end
    end

    // ------------------------------------------------------------------
    // Write item for the current idx.
    // ------------------------------------------------------------------
    logic [6:0] item_val;
    logic [7:0] item_addr, item_data;
    logic [2:0] item_last;

    always_comb begin
        item_val = '0;
        if (bank_q) begin
            case (idx)
                F_SEC:   item_val = t_sec;
                F_MIN:   item_val = t_min;
                F_HOUR:  item_val = t_hour;
                default: item_val = '0;
            endcase
        end else begin
            case (idx)
                F_SEC:   item_val = c_sec;
                F_MIN:   item_val = c_min;
                F_HOUR:  item_val = c_hour;
                F_DAY:   item_val = c_day;
                F_MONTH: item_val = c_month;
                F_YEAR:  item_val = c_year;
                default: item_val = '0;
            endcase
        end

        if (state == ST_INIT) begin
            item_addr = INIT_TBL[idx[1:0]][15:8];
            item_data = INIT_TBL[idx[1:0]][7:0];
            item_last = INIT_LAST;
        end else begin
            item_addr = (bank_q ? TIMER_BASE : CLOCK_BASE) + {5'd0, idx};
            item_data = bin2bcd(item_val);
            item_last = bank_q ? TIMER_LAST : CLOCK_LAST;
        end
    end

    // ------------------------------------------------------------------
    // Main FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            wr_req  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            editing <= 1'b0;
            busy    <= 1'b0;
            cursor  <= '0;
            idx     <= '0;
            bank_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_EDIT: begin
                    if (act_ini) begin
                        state   <= ST_INIT;
                        busy    <= 1'b1;
                        editing <= 1'b0;
                        idx     <= '0;
                    end else if (act_wr) begin
                        state   <= ST_COMMIT;
                        busy    <= 1'b1;
                        editing <= 1'b0;
                        idx     <= '0;
                        bank_q  <= clock_timer;
                    end else if (act_cfg) begin
                        if (state == ST_IDLE) begin
                            state   <= ST_EDIT;
                            editing <= 1'b1;
                            cursor  <= '0;
                        end else begin
                            state   <= ST_IDLE;
                            editing <= 1'b0;
                        end
                    end else if (state == ST_EDIT) begin
                        if (bank_chg)
                            cursor <= '0;
                        else if (act_r)
                            cursor <= (cursor >= last_idx) ? 3'd0 : cursor + 3'd1;
                        else if (act_l)
                            cursor <= (cursor == 3'd0) ? last_idx : cursor - 3'd1;
                        else if (timeout_hit) begin
                            state   <= ST_IDLE;
                            editing <= 1'b0;
                        end
                    end
                end

                ST_COMMIT, ST_INIT: begin
                    if (wr_req) begin
                        if (wr_ack) begin
                            wr_req <= 1'b0;
                            if (idx == item_last) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
                    end else begin
                        // Entry cycle or the one-cycle gap after an ack.
                        wr_req  <= 1'b1;
                        wr_addr <= item_addr;
                        wr_data <= item_data;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_edicion_rtc.sv
// tb_ctrl_edicion_rtc
// Directed bench for ctrl_edicion_rtc: editing, ranges, 12/24 h remap,
// cursor wrap, bank commit, init sequence and reset abort.

module tb_ctrl_edicion_rtc;
    import ctrl_rtc_pkg::*;

    localparam int K_CFG = 0;
    localparam int K_WR  = 1;
    localparam int K_INI = 2;
    localparam int K_UP  = 3;
    localparam int K_DN  = 4;
    localparam int K_L   = 5;
    localparam int K_R   = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       configurate = 1'b0, write = 1'b0, inicializate = 1'b0;
    logic       arriba = 1'b0, abajo = 1'b0, izquierda = 1'b0, derecha = 1'b0;
    logic       clock_timer = 1'b0, T24_12 = 1'b0, wr_ack = 1'b0;
    logic       wr_req, editing, busy;
    logic [7:0] wr_addr, wr_data, cursor_val;
    logic [2:0] cursor;
    state_t     fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    ctrl_edicion_rtc dut (
        .clk          (clk),
        .reset        (reset),
        .configurate  (configurate),
        .write        (write),
        .inicializate (inicializate),
        .arriba       (arriba),
        .abajo        (abajo),
        .izquierda    (izquierda),
        .derecha      (derecha),
        .clock_timer  (clock_timer),
        .T24_12       (T24_12),
        .wr_ack       (wr_ack),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .editing      (editing),
        .busy         (busy),
        .cursor       (cursor),
        .cursor_val   (cursor_val),
        .fsm_state    (fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle key pulse; returns at the negedge after the sampling edge.
    task automatic pulse(input int k);
        @(negedge clk);
        case (k)
            K_CFG:   configurate  = 1'b1;
            K_WR:    write        = 1'b1;
            K_INI:   inicializate = 1'b1;
            K_UP:    arriba       = 1'b1;
            K_DN:    abajo        = 1'b1;
            K_L:     izquierda    = 1'b1;
            default: derecha      = 1'b1;
        endcase
        @(negedge clk);
        configurate  = 1'b0;
        write        = 1'b0;
        inicializate = 1'b0;
        arriba       = 1'b0;
        abajo        = 1'b0;
        izquierda    = 1'b0;
        derecha      = 1'b0;
    endtask

    task automatic pulse_n(input int k, input int n);
        for (int i = 0; i < n; i++) pulse(k);
    endtask

    // Serves n write items from exp_q. Called at the negedge where wr_req
    // is expected to have just risen. hold = cycles before acking.
    // gap_ack_item keeps wr_ack high through that item's gap cycle.
    task automatic run_writes(input int n, input bit final_batch, input int hold,
                              input int gap_ack_item);
        for (int i = 0; i < n; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("req_up", wr_req, 1);
            check("addr", wr_addr, e[15:8]);
            check("data", wr_data, e[7:0]);
            check("busy_mid", busy, 1);
            repeat (hold) @(negedge clk);
            check("req_held", wr_req, 1);
            check("addr_held", wr_addr, e[15:8]);
            wr_ack = 1'b1;
            @(negedge clk);
            if (i != gap_ack_item) wr_ack = 1'b0;
            check("gap_low", wr_req, 0);
            if (final_batch && i == n - 1) begin
                check("busy_end", busy, 0);
                check("state_end", fsm_state, ST_IDLE);
            end else begin
                check("busy_gap", busy, 1);
                @(negedge clk);
                wr_ack = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] fld_exp[6];
        fld_exp = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req", wr_req, 0);
        check("rst_addr", wr_addr, 8'h00);
        check("rst_data", wr_data, 8'h00);
        check("rst_editing", editing, 0);
        check("rst_busy", busy, 0);
        check("rst_cursor", cursor, 0);
        check("rst_cursor_val", cursor_val, 8'h00);
        check("rst_state", fsm_state, ST_IDLE);
        reset = 1'b1;
        @(negedge clk);

        // enter EDIT, sec up x3
        pulse(K_CFG);
        check("edit_on", editing, 1);
        check("edit_cursor", cursor, 0);
        pulse_n(K_UP, 3);
        check("sec_3", cursor_val, 8'h03);

        // hour wrap in 24 h, remap into 12 h
        pulse_n(K_R, 2);
        check("cur_hour", cursor, 2);
        check("hour_0", cursor_val, 8'h00);
        pulse(K_DN);
        check("hour_dn_wrap", cursor_val, 8'h23);
        pulse(K_UP);
        check("hour_up_wrap", cursor_val, 8'h00);
        T24_12 = 1'b1;
        @(negedge clk);
        check("remap_0_12", cursor_val, 8'h12);
        pulse(K_UP);
        check("h12_up_wrap", cursor_val, 8'h01);
        pulse(K_DN);
        check("h12_dn_wrap", cursor_val, 8'h12);
        T24_12 = 1'b0;
        @(negedge clk);
        check("back_24_keep", cursor_val, 8'h12);
        pulse(K_UP);
        check("hour_13", cursor_val, 8'h13);
        T24_12 = 1'b1;
        @(negedge clk);
        check("remap_13_1", cursor_val, 8'h01);
        T24_12 = 1'b0;
        @(negedge clk);

        // min to 45, day/month/year lower wraps, cursor wraps
        pulse(K_L);
        check("cur_min", cursor, 1);
        pulse_n(K_DN, 15);
        check("min_45", cursor_val, 8'h45);
        pulse_n(K_R, 2);
        pulse(K_DN);
        check("day_wrap", cursor_val, 8'h31);
        pulse(K_R);
        pulse(K_DN);
        check("month_wrap", cursor_val, 8'h12);
        pulse(K_R);
        pulse(K_DN);
        check("year_wrap", cursor_val, 8'h99);
        pulse(K_R);
        check("clk_r_wrap", cursor, 0);
        pulse(K_L);
        check("clk_l_wrap", cursor, 5);

        // timer bank
        clock_timer = 1'b1;
        @(negedge clk);
        check("bank_cur0", cursor, 0);
        check("tsec_0", cursor_val, 8'h00);
        pulse(K_L);
        check("tmr_l_wrap", cursor, 2);
        check("thour_12", cursor_val, 8'h12);
        pulse(K_R);
        check("tmr_r_wrap", cursor, 0);
        clock_timer = 1'b0;
        @(negedge clk);
        check("bank_back", cursor, 0);
        check("csec_3", cursor_val, 8'h03);

        // commit clock bank, ack after 3 cycles, stray ack in a gap
        exp_q.push_back(16'h2103);
        exp_q.push_back(16'h2245);
        exp_q.push_back(16'h2301);
        exp_q.push_back(16'h2431);
        exp_q.push_back(16'h2512);
        exp_q.push_back(16'h2699);
        pulse(K_WR);
        check("cm_busy", busy, 1);
        check("cm_req0", wr_req, 0);
        check("cm_editing", editing, 0);
        @(negedge clk);
        run_writes(6, 1'b1, 3, 1);

        // init with same-cycle arriba
        pulse(K_CFG);
        check("edit2", editing, 1);
        @(negedge clk);
        inicializate = 1'b1;
        arriba       = 1'b1;
        @(negedge clk);
        inicializate = 1'b0;
        arriba       = 1'b0;
        check("init_state", fsm_state, ST_INIT);
        check("init_busy", busy, 1);
        exp_q.push_back(16'h0210);
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h10D2);
        @(negedge clk);
        run_writes(3, 1'b1, 0, -1);
        pulse(K_CFG);
        check("init_no_step", cursor_val, 8'h03);

        // arrows ignored in IDLE
        pulse(K_CFG);
        check("idle_again", editing, 0);
        pulse(K_UP);
        pulse(K_CFG);
        check("idle_arrow_ign", cursor_val, 8'h03);

        // reset while waiting on the third ack
        exp_q.push_back(16'h2103);
        exp_q.push_back(16'h2245);
        pulse(K_WR);
        @(negedge clk);
        run_writes(2, 1'b0, 1, -1);
        check("third_req", wr_req, 1);
        check("third_addr", wr_addr, 8'h23);
        check("third_data", wr_data, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        check("abort_req", wr_req, 0);
        check("abort_busy", busy, 0);
        check("abort_state", fsm_state, ST_IDLE);
        check("abort_val", cursor_val, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        pulse(K_CFG);
        for (int f = 0; f < 6; f++) begin
            check("field_min", cursor_val, fld_exp[f]);
            pulse(K_R);
        end
        check("field_sweep_wrap", cursor, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
